packet_sequencer: RTL and testbench

PACKET_SEQUENCER -- requirements
Module: packet_sequencer

---
 rtl/packet_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_packet_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_sequencer.sv
// Byte-stream packet sequencer: collects a 4-byte header, corrects it with a Hamming ECC,
// then forwards payload bytes and captures the trailing 2-byte packet CRC.

module packet_sequencer_ecc (
  input  logic [31:0] hdr,
  output logic [23:0] data,
  output logic        ok,
  output logic        corr,
  output logic        err
);

  // Parity-check column for each of the 24 header data bits (P5..P0).
  function automatic logic [5:0] ecc_col(input logic [4:0] i);
    case (i)
      5'd0:  return 6'h07;
      5'd1:  return 6'h0B;
      5'd2:  return 6'h0D;
      5'd3:  return 6'h0E;
      5'd4:  return 6'h13;
      5'd5:  return 6'h15;
      5'd6:  return 6'h16;
      5'd7:  return 6'h19;
      5'd8:  return 6'h1A;
      5'd9:  return 6'h1C;
      5'd10: return 6'h23;
      5'd11: return 6'h25;
      5'd12: return 6'h26;
      5'd13: return 6'h29;
      5'd14: return 6'h2A;
      5'd15: return 6'h2C;
      5'd16: return 6'h31;
      5'd17: return 6'h32;
      5'd18: return 6'h34;
      5'd19: return 6'h38;
      5'd20: return 6'h1F;
      5'd21: return 6'h2F;
      5'd22: return 6'h37;
      default: return 6'h3B;
    endcase
  endfunction

  logic [5:0] parity;
  logic [5:0] syndrome;
  logic       hit;
  logic       unused_rsvd;

  assign unused_rsvd = ^hdr[31:30];

  // A syndrome that matches one column flips that data bit; a one-hot syndrome is a
  // flipped ECC bit. Any other non-zero syndrome cannot be corrected.
  always_comb begin
    parity = '0;
    for (int i = 0; i < 24; i++)
      if (hdr[i]) parity = parity ^ ecc_col(i[4:0]);
    syndrome = parity ^ hdr[29:24];
    data = hdr[23:0];
    hit = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (syndrome == ecc_col(i[4:0])) begin
        data[i] = ~hdr[i];
        hit = 1'b1;
      end
    end
    ok   = (syndrome == 6'd0);
    corr = !ok && (hit || $onehot(syndrome));
    err  = !ok && !corr;
  end

endmodule

module packet_sequencer #(
  parameter logic [15:0] MAX_WC      = 16'd4096,
  parameter bit          DROP_ON_ERR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sot,
  input  logic        eot,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        hdr_valid,
  output logic [1:0]  vc,
  output logic [5:0]  dt,
  output logic [15:0] wc,
  output logic        hdr_ok,
  output logic        hdr_corr,
  output logic        hdr_err,
  output logic [7:0]  pay_data,
  output logic        pay_valid,
  output logic        pay_last,
  output logic [15:0] crc_out,
  output logic        pkt_done,
  output logic        pkt_abort
);

  typedef enum logic [2:0] {IDLE, HDR, CHECK, PAYLOAD, CRC, SKIP} state_t;

  state_t      state;
  logic [31:0] hdr;
  logic [1:0]  hdr_cnt;
  logic        crc_cnt;
  logic [15:0] pay_cnt;

  logic [23:0] fix_data;
  logic        ecc_ok, ecc_corr, ecc_err;
  logic        drop, is_short, completes;

  packet_sequencer_ecc u_ecc (
    .hdr  (hdr),
    .data (fix_data),
    .ok   (ecc_ok),
    .corr (ecc_corr),
    .err  (ecc_err)
  );

  assign drop      = ecc_err && DROP_ON_ERR;
  assign is_short  = (fix_data[5:0] <= 6'h0F);
  // A packet finishing this cycle wins over a simultaneous sot/eot abort.
  assign completes = (state == CHECK && !drop && is_short) ||
                     (state == CRC && byte_valid && crc_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hdr       <= '0;
      hdr_cnt   <= '0;
      crc_cnt   <= 1'b0;
      pay_cnt   <= '0;
      hdr_valid <= 1'b0;
      vc        <= '0;
      dt        <= '0;
      wc        <= '0;
      hdr_ok    <= 1'b0;
      hdr_corr  <= 1'b0;
      hdr_err   <= 1'b0;
      pay_data  <= '0;
      pay_valid <= 1'b0;
      pay_last  <= 1'b0;
      crc_out   <= '0;
      pkt_done  <= 1'b0;
      pkt_abort <= 1'b0;
    end else begin
      hdr_valid <= 1'b0;
      pay_valid <= 1'b0;
      pay_last  <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_abort <= 1'b0;
      case (state)
        IDLE: ;
        HDR: begin
          // Shifting in from the top leaves byte0 in [7:0] after four bytes.
          if (byte_valid) begin
            hdr     <= {byte_in, hdr[31:8]};
            hdr_cnt <= hdr_cnt + 2'd1;
            if (hdr_cnt == 2'd3) state <= CHECK;
          end
        end
        CHECK: begin
          hdr_valid <= 1'b1;
          vc        <= fix_data[7:6];
          dt        <= fix_data[5:0];
          wc        <= fix_data[23:8];
          hdr_ok    <= ecc_ok;
          hdr_corr  <= ecc_corr;
          hdr_err   <= ecc_err;
          pay_cnt   <= fix_data[23:8];
          crc_cnt   <= 1'b0;
          if (drop) state <= SKIP;
          else if (is_short) begin
            state    <= IDLE;
            pkt_done <= 1'b1;
          end else if (fix_data[23:8] == 16'd0) state <= CRC;
          else if (fix_data[23:8] > MAX_WC) begin
            state    <= SKIP;
            hdr_ok   <= 1'b0;
            hdr_corr <= 1'b0;
            hdr_err  <= 1'b1;
          end else state <= PAYLOAD;
        end
        PAYLOAD: begin
          if (byte_valid) begin
            pay_data  <= byte_in;
            pay_valid <= 1'b1;
            pay_cnt   <= pay_cnt - 16'd1;
            if (pay_cnt == 16'd1) begin
              pay_last <= 1'b1;
              state    <= CRC;
            end
          end
        end
        CRC: begin
          if (byte_valid) begin
            crc_cnt <= ~crc_cnt;
            if (!crc_cnt) crc_out[7:0] <= byte_in;
            else begin
              crc_out[15:8] <= byte_in;
              pkt_done      <= 1'b1;
              state         <= IDLE;
            end
          end
        end
        SKIP: ;
        default: state <= IDLE;
      endcase
      if ((sot || eot) && state != IDLE && !completes) begin
        pkt_abort <= 1'b1;
        hdr_valid <= 1'b0;
        state     <= IDLE;
      end
      if (sot) begin
        state   <= HDR;
        hdr_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_packet_sequencer.sv
// Directed bench for packet_sequencer: hand-computed header ECC bytes and expected
// decode results for clean, corrected, uncorrectable, short, aborted and oversize packets.

module tb_packet_sequencer;

  logic        clk;
  logic        rst_n;
  logic        sot, eot, byte_valid;
  logic [7:0]  byte_in;
  logic        hdr_valid, hdr_ok, hdr_corr, hdr_err;
  logic [1:0]  vc;
  logic [5:0]  dt;
  logic [15:0] wc, crc_out;
  logic [7:0]  pay_data;
  logic        pay_valid, pay_last, pkt_done, pkt_abort;

  int checks = 0;
  int errors = 0;

  int          mon_hdr_cnt, mon_pay_cnt, mon_last_cnt, mon_last_pos;
  int          mon_done_cnt, mon_abort_cnt, mon_done_with_hdr;
  logic [31:0] mon_pay_word;
  logic [1:0]  mon_vc;
  logic [5:0]  mon_dt;
  logic [15:0] mon_wc, mon_crc;
  logic        mon_ok, mon_corr, mon_err;

  packet_sequencer #(.MAX_WC(16'd4096), .DROP_ON_ERR(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sot        (sot),
    .eot        (eot),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .hdr_valid  (hdr_valid),
    .vc         (vc),
    .dt         (dt),
    .wc         (wc),
    .hdr_ok     (hdr_ok),
    .hdr_corr   (hdr_corr),
    .hdr_err    (hdr_err),
    .pay_data   (pay_data),
    .pay_valid  (pay_valid),
    .pay_last   (pay_last),
    .crc_out    (crc_out),
    .pkt_done   (pkt_done),
    .pkt_abort  (pkt_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output event shortly after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (hdr_valid) begin
      mon_hdr_cnt++;
      mon_vc = vc; mon_dt = dt; mon_wc = wc;
      mon_ok = hdr_ok; mon_corr = hdr_corr; mon_err = hdr_err;
      if (pkt_done) mon_done_with_hdr++;
    end
    if (pay_valid) begin
      mon_pay_cnt++;
      mon_pay_word = {mon_pay_word[23:0], pay_data};
      if (pay_last) begin
        mon_last_cnt++;
        mon_last_pos = mon_pay_cnt;
      end
    end
    if (pkt_done) begin
      mon_done_cnt++;
      mon_crc = crc_out;
    end
    if (pkt_abort) mon_abort_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearMonitor();
    mon_hdr_cnt = 0; mon_pay_cnt = 0; mon_last_cnt = 0; mon_last_pos = 0;
    mon_done_cnt = 0; mon_abort_cnt = 0; mon_done_with_hdr = 0;
    mon_pay_word = '0; mon_vc = '0; mon_dt = '0; mon_wc = '0; mon_crc = '0;
    mon_ok = 1'b0; mon_corr = 1'b0; mon_err = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    sot = 1'b0; eot = 1'b0;
    byte_in = b;
    byte_valid = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sot = 1'b0; eot = 1'b0; byte_valid = 1'b0;
    end
  endtask

  task automatic pulseSot();
    @(negedge clk);
    byte_valid = 1'b0; eot = 1'b0; sot = 1'b1;
    @(negedge clk);
    sot = 1'b0;
  endtask

  task automatic pulseEot();
    @(negedge clk);
    byte_valid = 1'b0; sot = 1'b0; eot = 1'b1;
    @(negedge clk);
    eot = 1'b0;
  endtask

  task automatic sendHeader(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    applyStimulus(b0);
    applyStimulus(b1);
    applyStimulus(b2);
    applyStimulus(b3);
    idleCycles(2);
  endtask

  task automatic sendBody();
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    applyStimulus(8'h5A);
    applyStimulus(8'hA5);
    idleCycles(3);
  endtask

  // DI=2A, WC=0004 carries ECC 33.
  task automatic runClean(input string tag);
    clearMonitor();
    pulseSot();
    sendHeader(8'h2A, 8'h04, 8'h00, 8'h33);
    sendBody();
    checkOutput({tag, "_hdr_cnt"}, mon_hdr_cnt, 1);
    checkOutput({tag, "_fields"}, {mon_vc, mon_dt, mon_wc}, {2'd0, 6'h2A, 16'h0004});
    checkOutput({tag, "_flags"}, {mon_ok, mon_corr, mon_err}, 3'b100);
    checkOutput({tag, "_pay"}, mon_pay_word, 32'h11223344);
    checkOutput({tag, "_last"}, {mon_last_cnt[7:0], mon_last_pos[7:0]}, 16'h0104);
    checkOutput({tag, "_done"}, mon_done_cnt, 1);
    checkOutput({tag, "_crc"}, mon_crc, 16'hA55A);
    checkOutput({tag, "_abort"}, mon_abort_cnt, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    sot = 1'b0; eot = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    clearMonitor();
    #12;
    checkOutput("rst_hdr", {hdr_valid, hdr_ok, hdr_corr, hdr_err}, 4'b0000);
    checkOutput("rst_fields", {vc, dt, wc}, 24'h0);
    checkOutput("rst_pay", {pay_valid, pay_last, pay_data}, 10'h0);
    checkOutput("rst_done", {pkt_done, pkt_abort, crc_out}, 18'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(2);

    runClean("clean");

    // Byte1 bit0 flipped: 04 -> 05, ECC still 33.
    clearMonitor();
    pulseSot();
    sendHeader(8'h2A, 8'h05, 8'h00, 8'h33);
    sendBody();
    checkOutput("corr_flags", {mon_ok, mon_corr, mon_err}, 3'b010);
    checkOutput("corr_wc", mon_wc, 16'h0004);
    checkOutput("corr_pay", mon_pay_word, 32'h11223344);
    checkOutput("corr_done", mon_done_cnt, 1);

    // Byte1 bits 0 and 1 flipped: uncorrectable, payload dropped until eot.
    clearMonitor();
    pulseSot();
    sendHeader(8'h2A, 8'h07, 8'h00, 8'h33);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    pulseEot();
    idleCycles(2);
    checkOutput("dbl_flags", {mon_ok, mon_corr, mon_err}, 3'b001);
    checkOutput("dbl_pay", mon_pay_cnt, 0);
    checkOutput("dbl_abort", mon_abort_cnt, 1);
    checkOutput("dbl_done", mon_done_cnt, 0);

    // Short frame-start packet DI=00, WC=0001, ECC 1A; stray bytes and eot afterwards are ignored.
    clearMonitor();
    pulseSot();
    sendHeader(8'h00, 8'h01, 8'h00, 8'h1A);
    applyStimulus(8'h77);
    applyStimulus(8'h88);
    pulseEot();
    idleCycles(2);
    checkOutput("short_hdr", {mon_dt, mon_wc}, {6'h00, 16'h0001});
    checkOutput("short_flags", {mon_ok, mon_corr, mon_err}, 3'b100);
    checkOutput("short_same_cycle", mon_done_with_hdr, 1);
    checkOutput("short_done", mon_done_cnt, 1);
    checkOutput("short_idle", {mon_pay_cnt[7:0], mon_abort_cnt[7:0]}, 16'h0000);

    // eot after two payload bytes.
    clearMonitor();
    pulseSot();
    sendHeader(8'h2A, 8'h04, 8'h00, 8'h33);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    pulseEot();
    idleCycles(2);
    checkOutput("eot_pay", mon_pay_cnt, 2);
    checkOutput("eot_abort", mon_abort_cnt, 1);
    checkOutput("eot_done", mon_done_cnt, 0);
    runClean("after_eot");

    // sot during payload restarts the header.
    clearMonitor();
    pulseSot();
    sendHeader(8'h2A, 8'h04, 8'h00, 8'h33);
    applyStimulus(8'h99);
    pulseSot();
    sendHeader(8'h2A, 8'h04, 8'h00, 8'h33);
    sendBody();
    checkOutput("resot_abort", mon_abort_cnt, 1);
    checkOutput("resot_hdr_cnt", mon_hdr_cnt, 2);
    checkOutput("resot_pay", {mon_pay_cnt[7:0], mon_pay_word}, {8'd5, 32'h11223344});
    checkOutput("resot_done", mon_done_cnt, 1);

    // WC=FFFF exceeds MAX_WC; header ECC 2A is valid, so hdr_err is forced.
    clearMonitor();
    pulseSot();
    sendHeader(8'h2A, 8'hFF, 8'hFF, 8'h2A);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    pulseEot();
    idleCycles(2);
    checkOutput("big_flags", {mon_ok, mon_corr, mon_err}, 3'b001);
    checkOutput("big_wc", mon_wc, 16'hFFFF);
    checkOutput("big_pay", mon_pay_cnt, 0);
    checkOutput("big_abort", mon_abort_cnt, 1);

    // Asynchronous reset mid-payload, between clock edges.
    runClean("pre_rst");
    pulseSot();
    sendHeader(8'h2A, 8'h04, 8'h00, 8'h33);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    @(posedge clk);
    #2;
    checkOutput("pre_rst_payvalid", pay_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_pay", {pay_valid, pay_data}, 9'h000);
    checkOutput("async_hdr", {wc, dt, hdr_ok}, 23'h0);
    checkOutput("async_crc", crc_out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    byte_valid = 1'b0;
    clearMonitor();
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    applyStimulus(8'h5A);
    applyStimulus(8'hA5);
    pulseEot();
    idleCycles(2);
    checkOutput("post_rst_quiet",
                {mon_hdr_cnt[7:0], mon_pay_cnt[7:0], mon_done_cnt[7:0], mon_abort_cnt[7:0]}, 32'h0);
    runClean("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
